// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    localparam cmp_result_t CMP_RESULT_NONE = '0;
    localparam cmp_result_t CMP_RESULT_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    function automatic cmp_result_t make_result(input logic lt, input logic eq, input logic gt);
        cmp_result_t r;
        r.lt = lt;
        r.eq = eq;
        r.gt = gt;
        return r;
    endfunction

endpackage

// File: rtl/comparator_seq_chunk_compare.sv
// Combinational unsigned compare of one W-bit operand chunk.
module chunk_compare #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_chunk,
    input  logic [W-1:0] b_chunk,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    always_comb begin
        lt = (a_chunk <  b_chunk);
        eq = (a_chunk == b_chunk);
        gt = (a_chunk >  b_chunk);
    end

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle from the MSB chunk.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to finish on the first differing chunk.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_lt,
    output logic             o_eq,
    output logic             o_gt
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CMP  = CMP;
    localparam logic [1:0] ST_DONE = DONE;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("comparator_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] msb_flip;
    logic             found;
    cmp_result_t      pend;
    cmp_result_t      res_q;
    logic             valid_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             c_lt;
    logic             c_eq;
    logic             c_gt;
    cmp_result_t      final_res;
    logic             finish;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    always_comb begin
        msb_flip            = '0;
        msb_flip[WIDTH-1]   = i_signed;
    end

    always_comb begin
        a_chunk = a_q[idx*CHUNK +: CHUNK];
        b_chunk = b_q[idx*CHUNK +: CHUNK];
    end

    chunk_compare #(
        .W (CHUNK)
    ) u_chunk_compare (
        .a_chunk (a_chunk),
        .b_chunk (b_chunk),
        .lt      (c_lt),
        .eq      (c_eq),
        .gt      (c_gt)
    );

    // The first differing chunk decides; later chunks only matter if none differed.
    always_comb begin
        if (found) begin
            final_res = pend;
        end else if (c_eq) begin
            final_res = CMP_RESULT_EQ;
        end else begin
            final_res = make_result(c_lt, 1'b0, c_gt);
        end
    end

    always_comb begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        finish = (!found && !c_eq) || (idx == '0);
`else
        finish = (idx == '0);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            idx     <= IDX_LAST;
            a_q     <= '0;
            b_q     <= '0;
            found   <= 1'b0;
            pend    <= CMP_RESULT_NONE;
            res_q   <= CMP_RESULT_NONE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_q   <= i_a ^ msb_flip;
                        b_q   <= i_b ^ msb_flip;
                        idx   <= IDX_LAST;
                        found <= 1'b0;
                        pend  <= CMP_RESULT_NONE;
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!found && !c_eq) begin
                        found <= 1'b1;
                        pend  <= make_result(c_lt, 1'b0, c_gt);
                    end
                    if (finish) begin
                        res_q   <= final_res;
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        res_q   <= CMP_RESULT_NONE;
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_ready = (state == ST_IDLE);
        o_valid = valid_q;
        o_lt    = res_q.lt;
        o_eq    = res_q.eq;
        o_gt    = res_q.gt;
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Directed self-checking bench for comparator_seq (WIDTH=32, CHUNK=8).
// Expected latencies follow COMPARATOR_SEQ_EARLY_EXIT_EN when defined for the build.
module tb_comparator_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] R_LT   = 3'b100;
    localparam logic [2:0] R_EQ   = 3'b010;
    localparam logic [2:0] R_GT   = 3'b001;
    localparam logic [2:0] R_NONE = 3'b000;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_signed;
    logic             o_valid;
    logic             i_ready;
    logic             o_lt;
    logic             o_eq;
    logic             o_gt;

    int n_checks = 0;
    int n_fail   = 0;

    comparator_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_lt     (o_lt),
        .o_eq     (o_eq),
        .o_gt     (o_gt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency for a first difference in chunk diff_idx (3 = MSB chunk); -1 means equal.
    function automatic int exp_lat(input int diff_idx);
        if (EARLY && diff_idx >= 0) return (WIDTH / CHUNK - diff_idx) + 1;
        return WIDTH / CHUNK + 1;
    endfunction

    // Present a request and return #1 after its accept edge (now in cycle 1).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        i_a      = a;
        i_b      = b;
        i_signed = s;
        i_valid  = 1'b1;
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid  = 1'b0;
        i_a      = ~a;
        i_b      = a;
        i_signed = ~s;
    endtask

    task automatic wait_result(input string tag, input logic [2:0] exp_flags, input int lat);
        int cyc = 1;
        while (!o_valid && cyc < 30) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check({tag, "_valid"},   {31'd0, o_valid}, 32'd1);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_flags"},   {29'd0, o_lt, o_eq, o_gt}, {29'd0, exp_flags});
        check({tag, "_ready_done"}, {31'd0, o_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_ready_idle"}, {31'd0, o_ready}, 32'd1);
        check({tag, "_flags_clr"}, {29'd0, o_lt, o_eq, o_gt}, {29'd0, R_NONE});
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [2:0] exp_flags, input int diff_idx);
        send(a, b, s);
        wait_result(tag, exp_flags, exp_lat(diff_idx));
        handshake(tag);
    endtask

    initial begin
        int stale;
        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_a      = '0;
        i_b      = '0;
        i_signed = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_flags", {29'd0, o_lt, o_eq, o_gt}, {29'd0, R_NONE});

        run("msb_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, R_GT, 3);
        run("msb_signed",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, R_LT, 3);
        run("eq_unsigned",  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, R_EQ, -1);
        run("eq_signed",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, R_EQ, -1);
        run("low_chunk_lt", 32'h1234_5601, 32'h1234_5602, 1'b0, R_LT, 0);
        run("neg1_vs_0",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, R_LT, 3);
        run("neg1_vs_0_u",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, R_GT, 3);
        run("chunk2_gt",    32'h00FF_0000, 32'h00FE_0000, 1'b0, R_GT, 2);
        run("chunk1_lt_s",  32'hFFFF_10FF, 32'hFFFF_20FF, 1'b1, R_LT, 1);

        // Backpressure: result held while a new request waits on i_valid.
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        wait_result("bp", R_GT, exp_lat(0));
        i_a     = 32'h0000_0001;
        i_b     = 32'h0000_0002;
        i_signed = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp_hold_flags", {29'd0, o_lt, o_eq, o_gt}, {29'd0, R_GT});
            check("bp_hold_ready", {31'd0, o_ready}, 32'd0);
        end
        handshake("bp");
        send(32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_result("bp_next", R_LT, exp_lat(0));
        handshake("bp_next");

        // Reset in the middle of CMP aborts the request.
        send(32'h0100_0000, 32'h0100_0001, 1'b0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        check("abort_flags", {29'd0, o_lt, o_eq, o_gt}, {29'd0, R_NONE});
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid || o_lt || o_eq || o_gt) stale++;
        end
        check("abort_no_stale", stale, 0);
        run("after_abort", 32'h0100_0000, 32'h0100_0001, 1'b0, R_LT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
